boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The module SHALL have parameter WORDLENGTH, default 32, giving the instruction word width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, giving the instruction-memory word-address width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: a single-cycle request to begin a load.
REQ-006 The module SHALL have port rx_data, input, 8 bits: the incoming program byte.
REQ-007 The module SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-008 The module SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The module SHALL have port mem_we, output, 1 bit: the instruction-memory write strobe.
REQ-010 The module SHALL have port mem_addr, output, ADDR_WIDTH bits: the instruction-memory word address.
REQ-011 The module SHALL have port mem_wdata, output, WORDLENGTH bits: the instruction word to write.
REQ-012 The module SHALL have port cpu_reset, output, 1 bit: holds the processor pipeline in reset.
REQ-013 The module SHALL have ports busy, done and error, outputs, 1 bit each: status flags.

Function
REQ-014 A byte SHALL be accepted only on a rising edge where rx_valid and rx_ready are both 1; bytes with rx_ready=0 SHALL be ignored, not lost by the sender.
REQ-015 The FSM SHALL have states IDLE, CNT_HI, CNT_LO, DATA, DONE and ERR.
REQ-016 rx_ready SHALL be 1 in CNT_HI, CNT_LO and DATA, and 0 in all other states.
REQ-017 busy SHALL be 1 in CNT_HI, CNT_LO and DATA; done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-018 From IDLE, DONE or ERR, start=1 SHALL move the FSM to CNT_HI, clear the word count and mem_addr to 0, and assert cpu_reset.
REQ-019 start SHALL be ignored in CNT_HI, CNT_LO and DATA.
REQ-020 In CNT_HI, the accepted byte SHALL be stored as word-count bits [15:8], and the FSM SHALL move to CNT_LO.
REQ-021 In CNT_LO, the accepted byte SHALL be stored as word-count bits [7:0].
REQ-022 On the CNT_LO acceptance, the FSM SHALL go to DONE if the count is 0, to ERR if the count exceeds 2^ADDR_WIDTH, and to DATA otherwise.
REQ-023 In DATA, bytes SHALL be assembled big-endian: the first byte goes to [31:24] and the fourth byte to [7:0], tracked by a 2-bit byte counter.
REQ-024 On the edge accepting a word's 4th byte, mem_we SHALL be registered to 1 for exactly one cycle, with mem_wdata holding the full word and mem_addr its word index.
REQ-025 mem_addr SHALL increment by 1 on the edge following each mem_we pulse.
REQ-026 A word index equal to 2^ADDR_WIDTH SHALL never be produced, because the count is already checked by REQ-022.
REQ-027 When the 4th byte of the last word is accepted, the FSM SHALL enter DONE on that same edge; the final mem_we pulse coincides with the first DONE cycle.
REQ-028 cpu_reset SHALL be 1 in all states except DONE, and SHALL fall on the edge after the final mem_we pulse, so the processor never runs before its last word is written.
REQ-029 Back-to-back bytes (rx_valid held at 1) SHALL be accepted one per cycle with no bubbles, including across word boundaries.
REQ-030 mem_we SHALL be 0 in every cycle other than those defined in REQ-024.
REQ-031 A word SHALL never be partially written.

Reset
REQ-032 On reset=1, at any time including mid-load, all outputs SHALL take these values asynchronously: state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0.
REQ-033 Any partially assembled word or count SHALL be discarded on reset, and a new start SHALL be required after reset.

Verification
REQ-034 The bench SHALL cover this case: start, then bytes 00 02 DE AD BE EF 12 34 56 78 back-to-back -> mem_we pulses at addr 0 with 0xDEADBEEF and at addr 1 with 0x12345678, then done=1 and cpu_reset=0.
REQ-035 The bench SHALL cover this case: start, then count 00 00 -> DONE directly, no mem_we pulse, and cpu_reset=0 one cycle after the CNT_LO acceptance.
REQ-036 The bench SHALL cover this case: start, then count 01 01 (257) with ADDR_WIDTH=8 -> error=1, rx_ready=0, cpu_reset=1, no writes; a later start restarts in CNT_HI.
REQ-037 The bench SHALL cover this case: rx_valid toggling 1/0 every cycle during a 1-word load of 0xCAFEF00D -> single write at addr 0 with 0xCAFEF00D, and the byte order is preserved.
REQ-038 The bench SHALL cover this case: reset pulsed after 2 data bytes of a 3-word load -> all outputs at reset values immediately; a fresh start and 1-word load writes addr 0 correctly.
REQ-039 The bench SHALL cover this case: start asserted repeatedly during DATA -> ignored, the load completes unchanged; start in DONE -> cpu_reset reasserts and mem_addr=0.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: streams a byte-serial program image into instruction memory,
// holding the CPU in reset until the last word has been written.
module boot_loader #(
    parameter int WORDLENGTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORDLENGTH-1:0] mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        DONE,
        ERR
    } state_t;

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_cnt_hi;
    logic [15:0]           r_remaining;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_shift;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [WORDLENGTH-1:0] r_mem_wdata;

    logic                  w_active;
    logic                  w_accept;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic [15:0]           w_count;

    always_comb begin
        w_active = 1'b0;
        unique case (r_state)
            CNT_HI, CNT_LO, DATA: w_active = 1'b1;
            default:              w_active = 1'b0;
        endcase
    end

    assign w_accept    = rx_valid & w_active;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = (r_remaining == 16'd1);
    assign w_count     = {r_cnt_hi, rx_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERR: begin
                if (start) w_next = CNT_HI;
            end
            CNT_HI: begin
                if (w_accept) w_next = CNT_LO;
            end
            CNT_LO: begin
                if (w_accept) begin
                    if (w_count == 16'd0)
                        w_next = DONE;
                    else if (33'(w_count) > MAX_WORDS)
                        w_next = ERR;
                    else
                        w_next = DATA;
                end
            end
            DATA: begin
                if (w_accept && w_last_byte && w_last_word)
                    w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_hi    <= '0;
            r_remaining <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (r_mem_we) r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            unique case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_cnt_hi    <= '0;
                        r_remaining <= '0;
                        r_byte_cnt  <= '0;
                        r_shift     <= '0;
                        r_mem_addr  <= '0;
                    end
                end
                CNT_HI: begin
                    if (w_accept) r_cnt_hi <= rx_data;
                end
                CNT_LO: begin
                    if (w_accept) r_remaining <= w_count;
                end
                DATA: begin
                    if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Whole word is committed at once on its 4th byte
                        if (w_last_byte) begin
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= WORDLENGTH'({r_shift, rx_data});
                            r_remaining <= r_remaining - 16'd1;
                        end else begin
                            r_shift <= {r_shift[15:0], rx_data};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready  = w_active;
    assign busy      = w_active;
    assign done      = (r_state == DONE);
    assign error     = (r_state == ERR);
    // Final write lands in the first DONE cycle; keep the CPU held through it
    assign cpu_reset = !((r_state == DONE) && !r_mem_we);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table vectors, directed corner cases and random loads
// against a queue-based model of the expected instruction-memory writes.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    boot_loader #(
        .WORDLENGTH(32),
        .ADDR_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [15:0] cnt;
        int          nsend;
        int          mode;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   n_writes = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we cycle must match the next expected write
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=none",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
                chk("wr_data", mem_wdata, mon_e.d);
                chk("wr_cpu_held", 32'(cpu_reset), 32'd1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b[$], input int mode,
                        input bit noise, output int cyc);
        int i;
        bit v;
        bit tog;
        i = 0;
        tog = 1'b1;
        cyc = 0;
        v = 1'b0;
        while (i < b.size() && cyc < 20 * b.size() + 20) begin
            case (mode)
                0: v = 1'b1;
                1: begin
                    v = tog;
                    tog = ~tog;
                end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            rx_valid = v;
            rx_data = v ? b[i] : 8'($urandom);
            if (noise) start = 1'($urandom_range(0, 1));
            if (v && rx_ready) i++;
            @(negedge clk);
            cyc++;
        end
        rx_valid = 1'b0;
        start = 1'b0;
        if (i < b.size()) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", i, b.size());
        end
    endtask

    task automatic end_check(input bit exp_done, input bit exp_err,
                             input int exp_nwr, input int wr0);
        chk("done", 32'(done), 32'(exp_done));
        chk("error", 32'(error), 32'(exp_err));
        chk("rx_ready_end", 32'(rx_ready), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("cpu_reset_first", 32'(cpu_reset), 32'(exp_err || exp_nwr > 0));
        chk("mem_we_first", 32'(mem_we), 32'(exp_nwr > 0));
        @(negedge clk);
        chk("cpu_reset_after", 32'(cpu_reset), 32'(exp_err));
        chk("mem_we_after", 32'(mem_we), 32'd0);
        chk("nwrites", 32'(n_writes - wr0), 32'(exp_nwr));
        chk("pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Model: a legal count writes each sent word, in order, at its index
    task automatic run_load(input logic [15:0] cnt, input logic [31:0] words[$],
                            input int mode, input bit noise, input bit exp_done,
                            input bit exp_err, input int exp_nwr);
        logic [7:0] b[$];
        wr_t e;
        int wr0;
        int cyc;
        b.push_back(cnt[15:8]);
        b.push_back(cnt[7:0]);
        for (int k = 0; k < words.size(); k++) begin
            for (int s = 3; s >= 0; s--) b.push_back(8'(words[k] >> (8 * s)));
            if (cnt >= 16'd1 && cnt <= 16'd256) begin
                e.a = 8'(k);
                e.d = words[k];
                exp_q.push_back(e);
            end
        end
        wr0 = n_writes;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'd0);
        feed(b, mode, noise, cyc);
        if (mode == 0) chk("b2b_cycles", 32'(cyc), 32'(b.size()));
        end_check(exp_done, exp_err, exp_nwr, wr0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] none[$];
        logic [7:0]  pb[$];
        logic [15:0] cnt;
        int          cyc;
        int          wr0;
        bit          err;

        vt[0] = '{16'd0,     0,   0, 1'b1, 1'b0, 0};
        vt[1] = '{16'd1,     1,   0, 1'b1, 1'b0, 1};
        vt[2] = '{16'd2,     2,   1, 1'b1, 1'b0, 2};
        vt[3] = '{16'd3,     3,   2, 1'b1, 1'b0, 3};
        vt[4] = '{16'd256,   256, 0, 1'b1, 1'b0, 256};
        vt[5] = '{16'd257,   0,   0, 1'b0, 1'b1, 0};
        vt[6] = '{16'hFFFF,  0,   0, 1'b0, 1'b1, 0};
        vt[7] = '{16'd5,     5,   2, 1'b1, 1'b0, 5};

        do_reset();
        check_reset_vals("por");

        // Two words back-to-back
        wq = {32'hDEADBEEF, 32'h12345678};
        run_load(16'h0002, wq, 0, 1'b0, 1'b1, 1'b0, 2);
        chk("two_word_final_addr", 32'(mem_addr), 32'd2);

        // Zero count finishes straight away
        run_load(16'h0000, none, 0, 1'b0, 1'b1, 1'b0, 0);

        // Over-long count goes to error and ignores further bytes
        wr0 = n_writes;
        run_load(16'h0101, none, 0, 1'b0, 1'b0, 1'b1, 0);
        rx_valid = 1'b1;
        rx_data = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_rx_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        chk("err_no_write", 32'(n_writes - wr0), 32'd0);
        chk("err_still", 32'(error), 32'd1);
        wq = {32'hA5A55A5A};
        run_load(16'h0001, wq, 0, 1'b0, 1'b1, 1'b0, 1);

        // Valid toggling every cycle
        wq = {32'hCAFEF00D};
        run_load(16'h0001, wq, 1, 1'b0, 1'b1, 1'b0, 1);

        // Asynchronous reset mid-word of a 3-word load
        pulse_start();
        pb = {8'h00, 8'h03, 8'hAA, 8'hBB};
        feed(pb, 0, 1'b0, cyc);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'(rx_ready | busy), 32'd0);
        end
        rx_valid = 1'b0;
        wq = {32'h01020304};
        run_load(16'h0001, wq, 0, 1'b0, 1'b1, 1'b0, 1);

        // start noise during the load is ignored; start in DONE restarts
        wq = {32'h0BADC0DE, 32'hFEEDFACE};
        run_load(16'h0002, wq, 0, 1'b1, 1'b1, 1'b0, 2);
        pulse_start();
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart_addr", 32'(mem_addr), 32'd0);
        chk("restart_ready", 32'(rx_ready), 32'd1);
        pb = {8'h00, 8'h00};
        feed(pb, 0, 1'b0, cyc);
        chk("restart_done", 32'(done), 32'd1);

        for (int v = 0; v < 8; v++) begin
            wq.delete();
            for (int k = 0; k < vt[v].nsend; k++) wq.push_back($urandom);
            run_load(vt[v].cnt, wq, vt[v].mode, 1'b0, vt[v].exp_done,
                     vt[v].exp_err, vt[v].exp_nwr);
        end

        for (int r = 0; r < 15; r++) begin
            if ($urandom_range(0, 7) == 0)
                cnt = 16'($urandom_range(257, 65535));
            else
                cnt = 16'($urandom_range(0, 12));
            err = (cnt > 16'd256);
            wq.delete();
            if (!err)
                for (int k = 0; k < int'(cnt); k++) wq.push_back($urandom);
            run_load(cnt, wq, 2, 1'($urandom_range(0, 1)), !err, err,
                     err ? 0 : int'(cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
